// File: rtl/memcopy_pkg.sv
// Shared types and constants for the MemCopy sequencer.
package memcopy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mc_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/memcopy_addr_gen.sv
// Source/destination word pointers and remaining-word counter for MemCopy.
// Pointers step by one word, ascending or descending, modulo 2^XLEN.
module memcopy_addr_gen
  import memcopy_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             backward,
  input  logic [XLEN-1:0]  src_base,
  input  logic [XLEN-1:0]  dst_base,
  input  logic [CNT_W-1:0] count,
  output logic [XLEN-1:0]  src_ptr,
  output logic [XLEN-1:0]  dst_ptr,
  output logic             last
);

  localparam logic [XLEN-1:0] STRIDE = XLEN'(WORD_BYTES);

  logic [XLEN-1:0]  src_r;
  logic [XLEN-1:0]  dst_r;
  logic [CNT_W-1:0] rem_r;
  logic             dir_r;
  logic [XLEN-1:0]  base_off_s;

  // Descending copies start at the last word of each region.
  always_comb begin
    base_off_s = '0;
    if (backward) begin
      base_off_s = XLEN'(count - CNT_W'(1)) * STRIDE;
    end else begin
      base_off_s = '0;
    end
  end

  // Pointer/counter state: load on start, step once per copied word.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_r <= '0;
      dst_r <= '0;
      rem_r <= '0;
      dir_r <= 1'b0;
    end else if (load) begin
      src_r <= src_base + base_off_s;
      dst_r <= dst_base + base_off_s;
      rem_r <= count;
      dir_r <= backward;
    end else if (step) begin
      if (dir_r) begin
        src_r <= src_r - STRIDE;
        dst_r <= dst_r - STRIDE;
      end else begin
        src_r <= src_r + STRIDE;
        dst_r <= dst_r + STRIDE;
      end
      rem_r <= rem_r - CNT_W'(1);
    end
  end

  assign src_ptr = src_r;
  assign dst_ptr = dst_r;
  assign last    = (rem_r == CNT_W'(1));

endmodule

// File: rtl/memcopy_sequencer.sv
// MemCopy sequencer: stalls the PC and copies count words through the data
// memory port. Define MEMCOPY_BACKWARD_EN for memmove-style overlap handling.
module memcopy_sequencer
  import memcopy_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] src_addr,
  input  logic [XLEN-1:0] dst_addr,
  input  logic [XLEN-1:0] count,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_wdata,
  output logic            busy,
  output logic            pc_en,
  output logic            done
);

  mc_state_t        state_r;
  mc_state_t        state_s;
  logic             load_s;
  logic             step_s;
  logic             backward_s;
  logic             last_s;
  logic [XLEN-1:0]  src_ptr_s;
  logic [XLEN-1:0]  dst_ptr_s;
  logic [XLEN-1:0]  wdata_r;
  logic [CNT_W-1:0] count_s;
  logic             unused_count_s;

  assign count_s        = count[CNT_W-1:0];
  assign unused_count_s = ^count[XLEN-1:CNT_W];

`ifdef MEMCOPY_BACKWARD_EN
  localparam int XW = XLEN + 1;
  logic [XLEN:0] span_end_s;

  // Overlap with destination above source must copy from the top down.
  always_comb begin
    span_end_s = {1'b0, src_addr} + (XW'(count_s) * XW'(WORD_BYTES));
    backward_s = (dst_addr > src_addr) && ({1'b0, dst_addr} < span_end_s);
  end
`else
  assign backward_s = 1'b0;
`endif

  memcopy_addr_gen #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .step     (step_s),
    .backward (backward_s),
    .src_base (src_addr),
    .dst_base (dst_addr),
    .count    (count_s),
    .src_ptr  (src_ptr_s),
    .dst_ptr  (dst_ptr_s),
    .last     (last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Last written word is held on mem_wdata outside WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_r <= '0;
    end else if (state_r == WRITE) begin
      wdata_r <= mem_rdata;
    end
  end

  // Next state and memory-port/PC control decode.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    step_s    = 1'b0;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = wdata_r;
    busy      = 1'b0;
    pc_en     = 1'b1;
    done      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s = 1'b1;
          if (count_s == '0) begin
            state_s = DONE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        busy     = 1'b1;
        pc_en    = 1'b0;
        mem_addr = src_ptr_s;
        mem_read = 1'b1;
        state_s  = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        pc_en     = 1'b0;
        mem_addr  = dst_ptr_s;
        // A reset on this edge must not commit a half-finished word.
        mem_write = ~rst;
        mem_wdata = mem_rdata;
        step_s    = 1'b1;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = READ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memcopy_sequencer.sv
// Directed self-checking bench for memcopy_sequencer with a synchronous-read
// data memory model.
module tb_memcopy_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] count;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        pc_en;
  logic        done;

  always #5 clk = ~clk;

  memcopy_sequencer #(.XLEN(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .count     (count),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .pc_en     (pc_en),
    .done      (done)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] rd_log [0:63];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = 32'd0;
  logic [31:0] pl_data = 32'd0;
  int unsigned pc_low_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Memory model plus activity monitors.
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_addr[11:2]];
    if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
    if (pl_en) mem[pl_addr[11:2]] <= pl_data;
    if (!pc_en) pc_low_cnt <= pc_low_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_read) begin
      rd_log[rd_cnt[5:0]] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Holds start until done (as a stalled instruction would), then releases.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] n, output int cyc);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    count    = n;
    @(negedge clk);
    cyc = 1;
    src_addr = 32'hDEAD_BEE0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  int          cyc;
  int unsigned pc0, dn0, rd0, wr0;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    src_addr = 32'd0;
    dst_addr = 32'd0;
    count    = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_pc_en", {31'd0, pc_en}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Basic four-word copy
    for (int i = 0; i < 4; i++) poke(32'h100 + 32'(4 * i), 32'(i + 1));
    pc0 = pc_low_cnt; dn0 = done_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    run_copy(32'h100, 32'h200, 32'd4, cyc);
    check("basic_latency", 32'(cyc), 32'd9);
    check("basic_pc_low", 32'(pc_low_cnt - pc0), 32'd8);
    check("basic_done_pulses", 32'(done_cnt - dn0), 32'd1);
    check("basic_reads", 32'(rd_cnt - rd0), 32'd4);
    check("basic_writes", 32'(wr_cnt - wr0), 32'd4);
    for (int i = 0; i < 4; i++) check("basic_data", mem[128 + i], 32'(i + 1));
    check("basic_wdata_hold", mem_wdata, 32'd4);
    check("basic_idle_addr", mem_addr, 32'd0);
    check("basic_idle_pc_en", {31'd0, pc_en}, 32'd1);

    // Zero count
    pc0 = pc_low_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    start = 1'b1; src_addr = 32'h100; dst_addr = 32'h600; count = 32'd0;
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_pc_en", {31'd0, pc_en}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("zero_done_clear", {31'd0, done}, 32'd0);
    check("zero_pc_low", 32'(pc_low_cnt - pc0), 32'd0);
    check("zero_reads", 32'(rd_cnt - rd0), 32'd0);
    check("zero_writes", 32'(wr_cnt - wr0), 32'd0);

    // Count truncation and source address wrap
    poke(32'hFFFF_FFFC, 32'hAAAA_0001);
    poke(32'h0000_0000, 32'hAAAA_0002);
    pc0 = pc_low_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    run_copy(32'hFFFF_FFFC, 32'h300, 32'h0001_0002, cyc);
    check("trunc_latency", 32'(cyc), 32'd5);
    check("trunc_pc_low", 32'(pc_low_cnt - pc0), 32'd4);
    check("trunc_writes", 32'(wr_cnt - wr0), 32'd2);
    check("trunc_rd_addr0", rd_log[rd0[5:0]], 32'hFFFF_FFFC);
    check("trunc_rd_addr1", rd_log[(rd0 + 1) & 32'd63], 32'h0000_0000);
    check("trunc_data0", mem[192], 32'hAAAA_0001);
    check("trunc_data1", mem[193], 32'hAAAA_0002);

    // Reset in the 5th copy cycle (READ of word 2)
    for (int i = 0; i < 3; i++) poke(32'h400 + 32'(4 * i), 32'h11 * 32'(i + 1));
    for (int i = 0; i < 3; i++) poke(32'h500 + 32'(4 * i), 32'hDEAD_0000);
    wr0 = wr_cnt;
    start = 1'b1; src_addr = 32'h400; dst_addr = 32'h500; count = 32'd8;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    check("midrst_read2", {31'd0, mem_read}, 32'd1);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy_after", {31'd0, busy}, 32'd0);
    check("midrst_pc_en", {31'd0, pc_en}, 32'd1);
    check("midrst_mem_read", {31'd0, mem_read}, 32'd0);
    check("midrst_writes", 32'(wr_cnt - wr0), 32'd2);
    check("midrst_word0", mem[320], 32'h11);
    check("midrst_word1", mem[321], 32'h22);
    check("midrst_word2", mem[322], 32'hDEAD_0000);
    @(negedge clk);
    check("midrst_idle", {31'd0, pc_en}, 32'd1);

    // Overlapping regions, destination one word above source
    poke(32'h100, 32'h0000_000A);
    poke(32'h104, 32'h0000_000B);
    poke(32'h108, 32'h0000_000C);
    run_copy(32'h100, 32'h104, 32'd3, cyc);
    check("ovl_latency", 32'(cyc), 32'd7);
    check("ovl_src0", mem[64], 32'h0000_000A);
`ifdef MEMCOPY_BACKWARD_EN
    check("ovl_d0", mem[65], 32'h0000_000A);
    check("ovl_d1", mem[66], 32'h0000_000B);
    check("ovl_d2", mem[67], 32'h0000_000C);
`else
    check("ovl_d0", mem[65], 32'h0000_000A);
    check("ovl_d1", mem[66], 32'h0000_000A);
    check("ovl_d2", mem[67], 32'h0000_000A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
